// File: rtl/fifo_sync_pkg.sv
// Shared constants for the fifo_sync_level FIFO: count width helper and the
// {wr_en,rd_en} operation encoding.
package fifo_sync_pkg;

    function automatic int cnt_w(input int w);
        return w + 1;
    endfunction

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_BOTH = 2'b11;

endpackage

// File: rtl/fifo_sync_mem.sv
// D x B register array: one synchronous write port, one asynchronous read
// port, asynchronous clear of all storage.
module fifo_sync_mem #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [W-1:0] w_addr,
    input  logic [B-1:0] w_data,
    input  logic [W-1:0] r_addr,
    output logic [B-1:0] r_data
);

    localparam int D = 2**W;

    logic [B-1:0] mem_q [D];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[w_addr] <= w_data;
        end
    end

    assign r_data = mem_q[r_addr];

endmodule

// File: rtl/fifo_sync_level.sv
// Single-clock show-ahead FIFO with occupancy count and programmable
// almost-full/almost-empty levels. Sticky overflow/underflow flags are built
// only when FIFO_SYNC_ERR_EN is defined.
module fifo_sync_level
    import fifo_sync_pkg::*;
#(
    parameter int B      = 8,
    parameter int W      = 4,
    parameter int AF_LVL = 2**W - 2,
    parameter int AE_LVL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [B-1:0]          w_data,
    output logic [B-1:0]          r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [cnt_w(W)-1:0]   count
`ifdef FIFO_SYNC_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
`endif
);

    localparam int            CW   = cnt_w(W);
    localparam logic [CW-1:0] D_C  = CW'(2**W);
    localparam logic [CW-1:0] AF_C = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C = CW'(AE_LVL);

    logic [W-1:0]  w_ptr_q, w_ptr_d;
    logic [W-1:0]  r_ptr_q, r_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q, ae_q, af_q;
    logic          rd_en, wr_en;

    // Full FIFO accepts a write only when a read frees a slot on the same edge.
    assign rd_en = rd & ~empty_q;
    assign wr_en = wr & (~full_q | rd_en);

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (wr_en) w_ptr_d = w_ptr_q + W'(1);
        if (rd_en) r_ptr_d = r_ptr_q + W'(1);
        case ({wr_en, rd_en})
            OP_PUSH: count_d = count_q + CW'(1);
            OP_POP:  count_d = count_q - CW'(1);
            OP_IDLE,
            OP_BOTH: count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= (AF_LVL == 0);
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == D_C);
            ae_q    <= (count_d <= AE_C);
            af_q    <= (count_d >= AF_C);
        end
    end

    fifo_sync_mem #(
        .B (B),
        .W (W)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_en),
        .w_addr (w_ptr_q),
        .w_data (w_data),
        .r_addr (r_ptr_q),
        .r_data (r_data)
    );

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;

`ifdef FIFO_SYNC_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A new error on the clearing edge wins over err_clr.
    assign ovf_d = (ovf_q & ~err_clr) | (wr & ~wr_en);
    assign udf_d = (udf_q & ~err_clr) | (rd & ~rd_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_level.sv
// Directed, table-driven bench for fifo_sync_level (W=4, AF=14, AE=2), with
// hand sequences for pass-through, wrap, reset and the FIFO_SYNC_ERR_EN flags.
module tb_fifo_sync_level;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] wd;
        logic       chk_head;
        logic [7:0] head;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       ae;
        logic       af;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd, wr;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty, full, ae, af;
    logic [4:0] count;
`ifdef FIFO_SYNC_ERR_EN
    logic       overflow, underflow, err_clr;
`endif

    int tests = 0;
    int fails = 0;

    vec_t vecs[34];

    always #5 clk = ~clk;

    fifo_sync_level #(
        .B (8),
        .W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd           (rd),
        .wr           (wr),
        .w_data       (w_data),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (ae),
        .almost_full  (af),
        .count        (count)
`ifdef FIFO_SYNC_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [7:0] d);
        rd     = r;
        wr     = w;
        w_data = d;
        @(posedge clk);
        #1;
        rd     = 1'b0;
        wr     = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int c, input logic e,
                             input logic f, input logic a_e, input logic a_f);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"},  32'(full),  32'(f));
        chk({tag, ".ae"},    32'(ae),    32'(a_e));
        chk({tag, ".af"},    32'(af),    32'(a_f));
    endtask

    initial begin
        int c;
        // 17 pushes (last one rejected), then 17 pops (last one rejected)
        for (int i = 0; i < 17; i++) begin
            c = (i < 16) ? i + 1 : 16;
            vecs[i] = '{rd: 1'b0, wr: 1'b1, wd: (i < 16) ? 8'(i) : 8'h55,
                        chk_head: 1'b0, head: 8'h00, cnt: 5'(c),
                        emp: 1'b0, ful: (c == 16), ae: (c <= 2), af: (c >= 14)};
        end
        for (int j = 0; j < 17; j++) begin
            c = (j < 16) ? 15 - j : 0;
            vecs[17 + j] = '{rd: 1'b1, wr: 1'b0, wd: 8'h00,
                             chk_head: (j < 16), head: 8'(j), cnt: 5'(c),
                             emp: (c == 0), ful: 1'b0, ae: (c <= 2), af: (c >= 14)};
        end

        rd = 1'b0; wr = 1'b0; w_data = 8'h00;
`ifdef FIFO_SYNC_ERR_EN
        err_clr = 1'b0;
`endif
        reset = 1'b1;
        #12;
        reset = 1'b0;
        #1;
        chk_state("rst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst.r_data", 32'(r_data), 32'h0);
`ifdef FIFO_SYNC_ERR_EN
        chk("rst.overflow",  32'(overflow),  32'h0);
        chk("rst.underflow", 32'(underflow), 32'h0);
`endif

        foreach (vecs[k]) begin
            if (vecs[k].chk_head) chk($sformatf("tbl%0d.head", k), 32'(r_data), 32'(vecs[k].head));
            step(vecs[k].rd, vecs[k].wr, vecs[k].wd);
            chk_state($sformatf("tbl%0d", k), int'(vecs[k].cnt), vecs[k].emp,
                      vecs[k].ful, vecs[k].ae, vecs[k].af);
        end

        // Full pass-through: old words leave, 0xA5 enters, count pinned at 16
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h80 + i));
        chk_state("fill", 16, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pt%0d.head", i), 32'(r_data), 32'(8'h80 + i));
            step(1'b1, 1'b1, 8'hA5);
            chk($sformatf("pt%0d.count", i), 32'(count), 32'd16);
            chk($sformatf("pt%0d.full", i),  32'(full),  32'd1);
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.head", i), 32'(r_data), 32'hA5);
            step(1'b1, 1'b0, 8'h00);
        end
        chk_state("drained", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Empty with rd&wr: write wins, no bypass
        step(1'b1, 1'b1, 8'h3C);
        chk_state("emp_rw", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("emp_rw.r_data", 32'(r_data), 32'h3C);
        step(1'b1, 1'b0, 8'h00);
        chk("emp_rw.pop", 32'(count), 32'd0);

        // Pointer wrap with alternating push/pop
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 8'(8'h40 + i));
            chk($sformatf("wrap%0d.c1", i), 32'(count), 32'd1);
            chk($sformatf("wrap%0d.data", i), 32'(r_data), 32'(8'h40 + i));
            step(1'b1, 1'b0, 8'h00);
            chk($sformatf("wrap%0d.c0", i), 32'(empty), 32'd1);
        end

`ifdef FIFO_SYNC_ERR_EN
        // reset to a clean state before exercising sticky flags
        reset = 1'b1; #2; reset = 1'b0; #1;
        step(1'b1, 1'b0, 8'h00);
        chk("udf.set", 32'(underflow), 32'd1);
        chk("udf.ovf0", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i));
        chk("udf.hold", 32'(underflow), 32'd1);
        step(1'b0, 1'b1, 8'hEE);
        chk("ovf.set", 32'(overflow), 32'd1);
        chk("ovf.count", 32'(count), 32'd16);
        step(1'b0, 1'b0, 8'h00);
        chk("ovf.hold", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        step(1'b0, 1'b1, 8'hEE);
        chk("clr.coinc_ovf", 32'(overflow), 32'd1);
        chk("clr.udf", 32'(underflow), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        chk("clr.ovf", 32'(overflow), 32'd0);
        reset = 1'b1; #2; reset = 1'b0; #1;
`endif

        // Asynchronous reset mid-fill
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h70 + i));
        chk("mid.count7", 32'(count), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("mid.async_count", 32'(count), 32'd0);
        chk("mid.async_empty", 32'(empty), 32'd1);
        chk("mid.async_rdata", 32'(r_data), 32'd0);
        wr = 1'b1; w_data = 8'h99;
        @(posedge clk); #1;
        chk("mid.held_count", 32'(count), 32'd0);
        reset = 1'b0;
        wr = 1'b0;
        step(1'b0, 1'b1, 8'h5A);
        chk("mid.after_count", 32'(count), 32'd1);
        chk("mid.after_rdata", 32'(r_data), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
